// File: rtl/regbank_debug_controller_if.sv
// Signal bundle between the register-bank debug controller and its surroundings:
// writeback/decode stages, debug unit, and the register bank itself.
interface regbank_debug_controller_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              wb_write;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] id_addr1;
    logic              dbg_wr_req;
    logic [ADDR_W-1:0] dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;
    logic              dbg_wr_ack;
    logic              dbg_dump_start;
    logic              dbg_out_valid;
    logic              dbg_out_ready;
    logic [DATA_W-1:0] dbg_out_data;
    logic [ADDR_W-1:0] dbg_out_idx;
    logic              dbg_dump_done;
    logic              pipe_stall;
    logic [ADDR_W-1:0] rb_addr1;
    logic [DATA_W-1:0] rb_reg1;
    logic [ADDR_W-1:0] rb_write_addr;
    logic [DATA_W-1:0] rb_write_data;
    logic              rb_reg_write;

    // Controller side.
    modport master (
        input  wb_write, wb_addr, wb_data, id_addr1,
        input  dbg_wr_req, dbg_wr_addr, dbg_wr_data, dbg_dump_start, dbg_out_ready,
        input  rb_reg1,
        output dbg_wr_ack, dbg_out_valid, dbg_out_data, dbg_out_idx, dbg_dump_done,
        output pipe_stall, rb_addr1, rb_write_addr, rb_write_data, rb_reg_write
    );

    // Pipeline / debug unit / bank side.
    modport slave (
        output wb_write, wb_addr, wb_data, id_addr1,
        output dbg_wr_req, dbg_wr_addr, dbg_wr_data, dbg_dump_start, dbg_out_ready,
        output rb_reg1,
        input  dbg_wr_ack, dbg_out_valid, dbg_out_data, dbg_out_idx, dbg_dump_done,
        input  pipe_stall, rb_addr1, rb_write_addr, rb_write_data, rb_reg_write
    );
endinterface

// File: rtl/regbank_debug_controller.sv
// Arbitrates the register bank write port (writeback vs debug) and read port 1
// (decode vs register-dump sequencer); stalls the pipeline during debug work.
//   state    | meaning
//   IDLE     | pipeline owns the bank, waiting for a debug request
//   DBG_WR   | debug write pending, commits in the first cycle without writeback
//   DUMP_RD  | read port 1 addresses register cnt
//   DUMP_CAP | bank output captured into the dump word
//   DUMP_OUT | dump word offered until the sink accepts it
module regbank_debug_controller #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic clock,
    input logic reset,
    regbank_debug_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, DBG_WR, DUMP_RD, DUMP_CAP, DUMP_OUT} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt;
    logic              out_valid, wr_ack, dump_done;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              commit, handshake, at_last;

    assign at_last = (cnt == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                // Ack cycle is skipped so a still-held request is not taken twice.
                if (bus.dbg_dump_start)
                    state_next = DUMP_RD;
                else if (bus.dbg_wr_req && !wr_ack)
                    state_next = DBG_WR;
            end
            DBG_WR: begin
                if (!bus.wb_write) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            DUMP_RD:  state_next = DUMP_CAP;
            DUMP_CAP: state_next = DUMP_OUT;
            DUMP_OUT: begin
                if (bus.dbg_out_ready) begin
                    handshake  = 1'b1;
                    state_next = at_last ? IDLE : DUMP_RD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            wr_ack    <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            wr_ack    <= commit;
            dump_done <= handshake && at_last;
            if (state == IDLE && bus.dbg_dump_start)
                cnt <= '0;
            if (state == DUMP_CAP) begin
                out_data  <= bus.rb_reg1;
                out_idx   <= cnt;
                out_valid <= 1'b1;
            end
            if (handshake) begin
                out_valid <= 1'b0;
                cnt       <= at_last ? '0 : cnt + 1'b1;
            end
        end
    end

    // Writeback always wins the write port; the debug write simply retries.
    always_comb begin
        bus.rb_write_addr = bus.wb_addr;
        bus.rb_write_data = bus.wb_data;
        bus.rb_reg_write  = bus.wb_write;
        if (!bus.wb_write && state == DBG_WR) begin
            bus.rb_write_addr = bus.dbg_wr_addr;
            bus.rb_write_data = bus.dbg_wr_data;
            bus.rb_reg_write  = 1'b1;
        end
    end

    assign bus.rb_addr1      = (state == DUMP_RD) ? cnt : bus.id_addr1;
    assign bus.pipe_stall    = (state != IDLE);
    assign bus.dbg_out_valid = out_valid;
    assign bus.dbg_out_data  = out_data;
    assign bus.dbg_out_idx   = out_idx;
    assign bus.dbg_wr_ack    = wr_ack;
    assign bus.dbg_dump_done = dump_done;
endmodule

// File: tb/tb_regbank_debug_controller.sv
// Directed bench for regbank_debug_controller with a behavioural register bank
// and a queue-based scoreboard checked by an independent monitor.
module tb_regbank_debug_controller;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clock;
    logic reset;
    regbank_debug_controller_if #(.ADDR_W(5), .DATA_W(32)) bus();

    regbank_debug_controller #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    logic mon_en = 1'b0;

    wr_t exp_wr[$];
    wr_t exp_word[$];
    int  exp_done_cyc[$];
    int  exp_ack_cyc[$];
    logic [31:0] exp_mem [32];
    logic [31:0] mem [32];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Register bank: write on negedge, registered read on posedge.
    always @(negedge clock) if (bus.rb_reg_write) mem[bus.rb_write_addr] <= bus.rb_write_data;
    always @(posedge clock) bus.rb_reg1 <= mem[bus.rb_addr1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0d expected=none", name, act);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_dump(input int n);
        for (int i = 0; i < n; i++) exp_word.push_back({5'(i), exp_mem[i]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, 32'(bus.pipe_stall), 32'd0);
        check({tag, "_valid"}, 32'(bus.dbg_out_valid), 32'd0);
        check({tag, "_data"},  bus.dbg_out_data, 32'd0);
        check({tag, "_idx"},   32'(bus.dbg_out_idx), 32'd0);
        check({tag, "_ack"},   32'(bus.dbg_wr_ack), 32'd0);
        check({tag, "_done"},  32'(bus.dbg_dump_done), 32'd0);
    endtask

    task automatic wait_done(input int prev, input int limit, input string name);
        int n;
        n = 0;
        while (done_cnt == prev && n < limit) begin
            tick();
            n++;
        end
        if (done_cnt == prev) fail({name, "_timeout"}, n);
    endtask

    task automatic wait_ack(input int limit, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.dbg_wr_ack && n < limit);
        if (!bus.dbg_wr_ack) fail({name, "_timeout"}, n);
        bus.dbg_wr_req = 1'b0;
    endtask

    // Monitor: pops and compares whenever the DUT presents something.
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic [4:0]  hold_idx;
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.rb_reg_write) begin
                if (exp_wr.size() == 0) fail("unexpected_write", int'(bus.rb_write_addr));
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_addr", 32'(bus.rb_write_addr), 32'(e.addr));
                    check("write_data", bus.rb_write_data, e.data);
                end
            end
            if (bus.dbg_out_valid && bus.dbg_out_ready) begin
                if (exp_word.size() == 0) fail("unexpected_word", int'(bus.dbg_out_idx));
                else begin
                    wr_t e;
                    e = exp_word.pop_front();
                    check("word_idx", 32'(bus.dbg_out_idx), 32'(e.addr));
                    check("word_data", bus.dbg_out_data, e.data);
                end
            end
            if (hold_pend) begin
                check("hold_valid", 32'(bus.dbg_out_valid), 32'd1);
                check("hold_data", bus.dbg_out_data, hold_data);
                check("hold_idx", 32'(bus.dbg_out_idx), 32'(hold_idx));
            end
            hold_pend = bus.dbg_out_valid && !bus.dbg_out_ready && !reset;
            hold_data = bus.dbg_out_data;
            hold_idx  = bus.dbg_out_idx;
            if (bus.dbg_wr_ack) begin
                if (exp_ack_cyc.size() == 0) fail("unexpected_ack", cyc);
                else check("ack_cycle", 32'(cyc), 32'(exp_ack_cyc.pop_front()));
            end
            if (bus.dbg_dump_done) begin
                done_cnt++;
                if (exp_done_cyc.size() == 0) fail("unexpected_done", cyc);
                else check("done_cycle", 32'(cyc), 32'(exp_done_cyc.pop_front()));
            end
            if (bus.pipe_stall) stall_cnt++;
        end
    end

    initial begin
        int c, d0, s0, hold, n;
        logic [31:0] v;
        reset = 1'b1;
        bus.wb_write = 1'b0;       bus.wb_addr = '0;      bus.wb_data = '0;
        bus.id_addr1 = '0;         bus.dbg_wr_req = 1'b0; bus.dbg_wr_addr = '0;
        bus.dbg_wr_data = '0;      bus.dbg_dump_start = 1'b0;
        bus.dbg_out_ready = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        // Plain writeback, then decode read-back.
        bus.wb_write = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
        exp_wr.push_back({5'd5, 32'hDEADBEEF});
        exp_mem[5] = 32'hDEADBEEF;
        #1 check("wb_stall", 32'(bus.pipe_stall), 32'd0);
        tick();
        bus.wb_write = 1'b0;
        bus.id_addr1 = 5'd5;
        #1 check("id_addr_route", 32'(bus.rb_addr1), 32'd5);
        tick();
        check("readback_r5", bus.rb_reg1, 32'hDEADBEEF);

        // Preload reg i = i*0x11111111.
        for (int i = 0; i < 32; i++) begin
            v = 32'(i) * 32'h11111111;
            bus.wb_write = 1'b1; bus.wb_addr = 5'(i); bus.wb_data = v;
            exp_wr.push_back({5'(i), v});
            exp_mem[i] = v;
            tick();
        end
        bus.wb_write = 1'b0;

        // Full dump, sink always ready: done 96 cycles after the start edge.
        bus.dbg_out_ready = 1'b1;
        push_dump(32);
        exp_done_cyc.push_back(cyc + 97);
        s0 = stall_cnt; d0 = done_cnt;
        bus.dbg_dump_start = 1'b1;
        tick();
        bus.dbg_dump_start = 1'b0;
        wait_done(d0, 200, "dump1");
        check("dump1_stall_cycles", 32'(stall_cnt - s0), 32'd96);

        // Dump with 10 cycles of back-pressure on idx 7.
        bus.dbg_out_ready = 1'b0;
        push_dump(32);
        exp_done_cyc.push_back(cyc + 107);
        d0 = done_cnt; hold = 0; n = 0;
        bus.dbg_dump_start = 1'b1;
        tick();
        bus.dbg_dump_start = 1'b0;
        while (done_cnt == d0 && n < 300) begin
            if (bus.dbg_out_valid && bus.dbg_out_idx == 5'd7 && hold < 10) begin
                bus.dbg_out_ready = 1'b0;
                hold++;
            end else begin
                bus.dbg_out_ready = bus.dbg_out_valid;
            end
            tick();
            n++;
        end
        if (done_cnt == d0) fail("dump_bp_timeout", n);
        bus.dbg_out_ready = 1'b1;

        // Debug write blocked by two writebacks, commits on the third cycle.
        c = cyc;
        bus.wb_write = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'hA1A1A1A1;
        bus.dbg_wr_req = 1'b1; bus.dbg_wr_addr = 5'd3; bus.dbg_wr_data = 32'h12345678;
        exp_wr.push_back({5'd10, 32'hA1A1A1A1});
        exp_wr.push_back({5'd11, 32'hB2B2B2B2});
        exp_wr.push_back({5'd3, 32'h12345678});
        exp_ack_cyc.push_back(c + 3);
        exp_mem[10] = 32'hA1A1A1A1; exp_mem[11] = 32'hB2B2B2B2; exp_mem[3] = 32'h12345678;
        tick();
        bus.wb_addr = 5'd11; bus.wb_data = 32'hB2B2B2B2;
        tick();
        bus.wb_write = 1'b0;
        wait_ack(20, "dbgwr");
        bus.id_addr1 = 5'd3;
        tick();
        check("readback_r3", bus.rb_reg1, 32'h12345678);

        // Dump and write requested together: dump first, then the write.
        c = cyc;
        push_dump(32);
        exp_done_cyc.push_back(c + 97);
        exp_ack_cyc.push_back(c + 99);
        exp_wr.push_back({5'd20, 32'hCAFEF00D});
        bus.dbg_dump_start = 1'b1;
        bus.dbg_wr_req = 1'b1; bus.dbg_wr_addr = 5'd20; bus.dbg_wr_data = 32'hCAFEF00D;
        tick();
        bus.dbg_dump_start = 1'b0;
        wait_ack(200, "both");
        exp_mem[20] = 32'hCAFEF00D;
        bus.id_addr1 = 5'd20;
        tick();
        check("readback_r20", bus.rb_reg1, 32'hCAFEF00D);

        // Reset while idx 12 is on offer: abort with no done pulse.
        push_dump(12);
        bus.dbg_dump_start = 1'b1;
        tick();
        bus.dbg_dump_start = 1'b0;
        n = 0;
        while (!(bus.dbg_out_valid && bus.dbg_out_idx == 5'd12) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail("abort_wait_timeout", n);
        bus.dbg_out_ready = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        reset = 1'b0;
        bus.dbg_out_ready = 1'b1;

        // Fresh dump restarts at idx 0.
        push_dump(32);
        exp_done_cyc.push_back(cyc + 97);
        d0 = done_cnt;
        bus.dbg_dump_start = 1'b1;
        tick();
        bus.dbg_dump_start = 1'b0;
        wait_done(d0, 200, "dump_restart");

        repeat (4) tick();
        check("left_words", 32'(exp_word.size()), 32'd0);
        check("left_writes", 32'(exp_wr.size()), 32'd0);
        check("left_acks", 32'(exp_ack_cyc.size()), 32'd0);
        check("left_dones", 32'(exp_done_cyc.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
